// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: drives a sync-read imem and registers fetched words for decode.
// Latency: an instruction reaches IF/ID two edges after its address is presented (1 mem + 1 reg).
// Backpressure: stall holds PC and IF/ID, and a one-entry skid captures the in-flight read so release is bubble-free.
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] if_id_instruction,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid
);

    // Next address to present to memory.
    logic [31:0] pc;
    // A read was issued last cycle; imem_rdata now carries the word for rsp_pc.
    logic        rsp_valid;
    logic [31:0] rsp_pc;
    // Hold buffer for a read that completed while decode was stalled.
    logic        skid_valid;
    logic [31:0] skid_instr;
    logic [31:0] skid_pc;

    logic [31:0] target_aligned;
    assign target_aligned = {branch_target[31:2], 2'b00};

    // Memory request: a redirect always fetches its target (even under stall); a stall suppresses the read.
    always_comb begin
        imem_req  = 1'b0;
        imem_addr = pc;
        if (!reset) begin
            if (branch_taken) begin
                imem_req  = 1'b1;
                imem_addr = target_aligned;
            end else if (!stall) begin
                imem_req  = 1'b1;
            end
        end
    end

    // Fetch state and IF/ID register update; priority is reset > redirect > stall > normal.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc                <= RESET_PC;
            rsp_valid         <= 1'b0;
            rsp_pc            <= 32'h0000_0000;
            skid_valid        <= 1'b0;
            skid_instr        <= NOP_INSTR;
            skid_pc           <= 32'h0000_0000;
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
            if_id_pc          <= 32'h0000_0000;
        end else if (branch_taken) begin
            // Flush: anything in flight or parked in the skid belongs to the wrong path.
            pc                <= imem_addr + 32'd4;
            rsp_valid         <= 1'b1;
            rsp_pc            <= imem_addr;
            skid_valid        <= 1'b0;
            if_id_valid       <= 1'b0;
            if_id_instruction <= NOP_INSTR;
        end else if (stall) begin
            // Park the read returning now; no new read is issued, so nothing else can arrive.
            if (rsp_valid && !skid_valid) begin
                skid_valid <= 1'b1;
                skid_instr <= imem_rdata;
                skid_pc    <= rsp_pc;
            end
            rsp_valid <= 1'b0;
        end else begin
            pc        <= imem_addr + 32'd4;
            rsp_valid <= 1'b1;
            rsp_pc    <= imem_addr;
            if (skid_valid) begin
                if_id_valid       <= 1'b1;
                if_id_instruction <= skid_instr;
                if_id_pc          <= skid_pc;
                skid_valid        <= 1'b0;
            end else if (rsp_valid) begin
                if_id_valid       <= 1'b1;
                if_id_instruction <= imem_rdata;
                if_id_pc          <= rsp_pc;
            end else begin
                if_id_valid       <= 1'b0;
                if_id_instruction <= NOP_INSTR;
            end
        end
    end

    // A live response and a parked word together would mean one of them gets dropped.
    a_no_rsp_and_skid: assert property (@(posedge clk) disable iff (reset)
        !stall |-> !(rsp_valid && skid_valid));

endmodule
